// File: rtl/mcu_raster_writer.sv
// mcu_raster_writer
// Collects reconstructed 8x8 blocks (block after block, row-major inside a
// block) into one bank of a ping-pong buffer and re-emits the strip in raster
// order, one pixel per clock, while the other bank fills.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   in_valid/in_ready/in_pix/in_first   block pixel input, in_first marks
//                  pixel 0 of block 0 of a strip
//   out_valid/out_ready/out_pix         raster pixel output
//   out_line_end   last pixel of a raster line
//   out_strip_end  last pixel of the strip
//   sync_err       one-cycle pulse after a resync drops a partial strip
//
// Reader FSM
//   state  | meaning
//   IDLE   | waiting for the issue bank to become full
//   STREAM | issuing bank reads at ra, one per cycle while credit allows
module mcu_raster_writer #(
  parameter int Total_MCUs = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pix,
  input  logic       in_first,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pix,
  output logic       out_line_end,
  output logic       out_strip_end,
  output logic       sync_err
);

  localparam int W     = 8 * Total_MCUs;
  localparam int DEPTH = 64 * Total_MCUs;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (Total_MCUs > 1) ? $clog2(Total_MCUs) : 1;
  localparam int CW    = $clog2(W);
  localparam int MEMD  = 2 ** (AW + 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d, rb_q, rb_d, ib_q, ib_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [5:0]    k_q, k_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [CW-1:0] col_q, col_d;
  logic          sync_err_q, sync_err_d;
  logic          rd_v_q, rd_v_d, rd_le_q, rd_le_d, rd_se_q, rd_se_d;
  logic [7:0]    rd_pix_q;
  logic          sk_v_q, sk_v_d, sk_le_q, sk_le_d, sk_se_q, sk_se_d;
  logic [7:0]    sk_pix_q, sk_pix_d;
  logic          ov_q, ov_d, ole_q, ole_d, ose_q, ose_d;
  logic [7:0]    op_q, op_d;

  logic [7:0]    mem [MEMD];

  logic          acc, resync, issue, pop, credit_ok;
  logic [5:0]    wk;
  logic [BW-1:0] wblk;
  logic [AW-1:0] waddr;
  logic [1:0]    occ;

  assign in_ready      = !rst && !full_q[wb_q];
  assign out_valid     = ov_q;
  assign out_pix       = op_q;
  assign out_line_end  = ole_q;
  assign out_strip_end = ose_q;
  assign sync_err      = sync_err_q;

  // Writer: scatter block pixels into raster positions of the write bank.
  assign acc    = in_valid && in_ready;
  assign resync = acc && in_first && ((blk_q != '0) || (k_q != 6'd0));
  assign wk     = resync ? 6'd0 : k_q;
  assign wblk   = resync ? '0 : blk_q;
  assign waddr  = AW'(wk[5:3]) * AW'(W) + AW'({wblk, 3'b000}) + AW'(wk[2:0]);

  // Reader credit: bank read in flight + skid + output register never exceed
  // two pixels, so a read issued now always has somewhere to land.
  assign pop       = ov_q && out_ready;
  assign occ       = {1'b0, ov_q} + {1'b0, sk_v_q} + {1'b0, rd_v_q};
  assign credit_ok = pop || (occ < 2'd2);

  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    blk_d      = blk_q;
    k_d        = k_q;
    sync_err_d = resync;

    if (acc) begin
      if (resync) begin
        blk_d = '0;
        k_d   = 6'd1;
      end else if (k_q == 6'd63) begin
        k_d = 6'd0;
        if (blk_q == BW'(Total_MCUs - 1)) begin
          blk_d        = '0;
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end else begin
        k_d = k_q + 6'd1;
      end
    end

    // Bank is released only when its strip_end pixel leaves the block.
    if (pop && ose_q) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  // Issue side runs one bank ahead of rb so the next strip is prefetched
  // and follows strip_end with no gap.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    col_d   = col_q;
    ib_d    = ib_q;
    issue   = 1'b0;

    case (state_q)
      IDLE: begin
        if (full_q[ib_q] && credit_ok) begin
          issue   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (credit_ok) issue = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      if (ra_q == AW'(DEPTH - 1)) begin
        ra_d    = '0;
        col_d   = '0;
        ib_d    = ~ib_q;
        state_d = IDLE;
      end else begin
        ra_d  = ra_q + AW'(1);
        col_d = (col_q == CW'(W - 1)) ? '0 : col_q + CW'(1);
      end
    end

    rd_v_d  = issue;
    rd_le_d = (col_q == CW'(W - 1));
    rd_se_d = (ra_q == AW'(DEPTH - 1));
  end

  // Output register with one-entry skid.
  always_comb begin
    ov_d     = ov_q;
    op_d     = op_q;
    ole_d    = ole_q;
    ose_d    = ose_q;
    sk_v_d   = sk_v_q;
    sk_pix_d = sk_pix_q;
    sk_le_d  = sk_le_q;
    sk_se_d  = sk_se_q;

    if (!ov_q || pop) begin
      if (sk_v_q) begin
        ov_d     = 1'b1;
        op_d     = sk_pix_q;
        ole_d    = sk_le_q;
        ose_d    = sk_se_q;
        sk_v_d   = rd_v_q;
        sk_pix_d = rd_pix_q;
        sk_le_d  = rd_le_q;
        sk_se_d  = rd_se_q;
      end else if (rd_v_q) begin
        ov_d  = 1'b1;
        op_d  = rd_pix_q;
        ole_d = rd_le_q;
        ose_d = rd_se_q;
      end else begin
        ov_d = 1'b0;
      end
    end else if (rd_v_q) begin
      sk_v_d   = 1'b1;
      sk_pix_d = rd_pix_q;
      sk_le_d  = rd_le_q;
      sk_se_d  = rd_se_q;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[{wb_q, waddr}] <= in_pix;
    if (issue) rd_pix_q <= mem[{ib_q, ra_q}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      full_q     <= 2'b00;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      ib_q       <= 1'b0;
      blk_q      <= '0;
      k_q        <= 6'd0;
      ra_q       <= '0;
      col_q      <= '0;
      sync_err_q <= 1'b0;
      rd_v_q     <= 1'b0;
      rd_le_q    <= 1'b0;
      rd_se_q    <= 1'b0;
      sk_v_q     <= 1'b0;
      sk_pix_q   <= 8'd0;
      sk_le_q    <= 1'b0;
      sk_se_q    <= 1'b0;
      ov_q       <= 1'b0;
      op_q       <= 8'd0;
      ole_q      <= 1'b0;
      ose_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      ib_q       <= ib_d;
      blk_q      <= blk_d;
      k_q        <= k_d;
      ra_q       <= ra_d;
      col_q      <= col_d;
      sync_err_q <= sync_err_d;
      rd_v_q     <= rd_v_d;
      rd_le_q    <= rd_le_d;
      rd_se_q    <= rd_se_d;
      sk_v_q     <= sk_v_d;
      sk_pix_q   <= sk_pix_d;
      sk_le_q    <= sk_le_d;
      sk_se_q    <= sk_se_d;
      ov_q       <= ov_d;
      op_q       <= op_d;
      ole_q      <= ole_d;
      ose_q      <= ose_d;
    end
  end

endmodule

// File: tb/tb_mcu_raster_writer.sv
// Scoreboard bench for mcu_raster_writer: a Total_MCUs=2 instance carries
// most scenarios, a Total_MCUs=1 instance checks the degenerate strip.
module tb_mcu_raster_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, in_first, out_valid, out_ready;
  logic       out_line_end, out_strip_end, sync_err;
  logic [7:0] in_pix, out_pix;

  logic       in_valid_1, in_ready_1, in_first_1, out_valid_1, out_ready_1;
  logic       out_line_end_1, out_strip_end_1, sync_err_1;
  logic [7:0] in_pix_1, out_pix_1;

  mcu_raster_writer #(.Total_MCUs(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_line_end(out_line_end), .out_strip_end(out_strip_end), .sync_err(sync_err)
  );

  mcu_raster_writer #(.Total_MCUs(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .in_pix(in_pix_1), .in_first(in_first_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_pix(out_pix_1),
    .out_line_end(out_line_end_1), .out_strip_end(out_strip_end_1), .sync_err(sync_err_1)
  );

  int checks = 0;
  int errors = 0;
  int out_cnt = 0, out_cnt1 = 0, acc_cnt = 0, sync_cnt = 0;
  logic [9:0] q2[$];
  logic [9:0] q1[$];
  logic [9:0] exp2, exp1, hold;
  logic       hold_v = 1'b0;
  bit         snd_done, tog_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for the Total_MCUs=2 instance: pops on every transfer and
  // checks the output holds steady across stalls.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!out_valid || {out_pix, out_line_end, out_strip_end} !== hold) begin
          errors++;
          $display("FAIL stall_hold actual=%0b_%0h expected=1_%0h", out_valid,
                   {out_pix, out_line_end, out_strip_end}, hold);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL out_extra actual=%0h expected=none", {out_pix, out_line_end, out_strip_end});
        end else begin
          exp2 = q2.pop_front();
          if ({out_pix, out_line_end, out_strip_end} !== exp2) begin
            errors++;
            $display("FAIL out_pix idx=%0d actual=%0h expected=%0h", out_cnt,
                     {out_pix, out_line_end, out_strip_end}, exp2);
          end
        end
        out_cnt++;
      end
      hold_v = out_valid && !out_ready;
      hold   = {out_pix, out_line_end, out_strip_end};
      if (sync_err) sync_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && out_valid_1 && out_ready_1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_extra actual=%0h expected=none", {out_pix_1, out_line_end_1, out_strip_end_1});
      end else begin
        exp1 = q1.pop_front();
        if ({out_pix_1, out_line_end_1, out_strip_end_1} !== exp1) begin
          errors++;
          $display("FAIL out1_pix idx=%0d actual=%0h expected=%0h", out_cnt1,
                   {out_pix_1, out_line_end_1, out_strip_end_1}, exp1);
        end
      end
      out_cnt1++;
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one pixel and hold it until accepted; returns 1ns after the edge.
  task automatic send2(input logic [7:0] px, input logic first);
    int  n;
    logic rdy;
    in_valid = 1'b1; in_pix = px; in_first = first; n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 5000);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=stalled expected=accepted");
    end else begin
      acc_cnt++;
    end
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic send1(input logic [7:0] px, input logic first);
    int  n;
    logic rdy;
    in_valid_1 = 1'b1; in_pix_1 = px; in_first_1 = first; n = 0;
    do begin
      @(negedge clk); rdy = in_ready_1;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 5000);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL accept1_timeout actual=stalled expected=accepted");
    end
    in_valid_1 = 1'b0; in_first_1 = 1'b0;
  endtask

  // Block0 pixel k = v0+k (pixel 0 = p0), block1 pixel k = v1+k.
  // Raster pixel i sits at row i/16, column i%16 -> block c/8, k = row*8 + c%8.
  task automatic send_strip(input int v0, input int v1, input int p0, input bit lat);
    int r, c, k, val;
    for (int i = 0; i < 128; i++) begin
      r = i / 16; c = i % 16; k = r * 8 + c % 8;
      if (c < 8) val = (k == 0) ? p0 : v0 + k;
      else       val = v1 + k;
      q2.push_back({val[7:0], (c == 15), (i == 127)});
    end
    for (int b = 0; b < 2; b++)
      for (int kk = 0; kk < 64; kk++) begin
        if (b == 0) val = (kk == 0) ? p0 : v0 + kk;
        else        val = v1 + kk;
        send2(val[7:0], (b == 0 && kk == 0));
      end
    if (lat) begin
      @(negedge clk); chk("lat_e0", out_valid, 0);
      @(negedge clk); chk("lat_e1", out_valid, 0);
      @(negedge clk); chk("lat_e2", out_valid, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((q2.size() != 0 || q1.size() != 0) && n < max) begin
      @(posedge clk); n++;
    end
    #1;
    checks++;
    if (q2.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", q2.size() + q1.size());
    end
  endtask

  initial begin
    int base, acc0, s0, n;
    logic prev_rdy;

    rst = 1'b1;
    in_valid = 0; in_pix = 0; in_first = 0; out_ready = 1;
    in_valid_1 = 0; in_pix_1 = 0; in_first_1 = 0; out_ready_1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdy_in_rst", in_ready, 0);
    chk("rdy1_in_rst", in_ready_1, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_line_end", out_line_end, 0);
    chk("rst_strip_end", out_strip_end, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst1_in_ready", in_ready_1, 1);
    @(posedge clk); #1;

    // Basic strip, free-running sink, latency check.
    send_strip(0, 100, 0, 1);
    wait_drain(2000);
    chk("t1_count", out_cnt, 128);

    // Sink blocked, three strips offered.
    base = out_cnt; acc0 = acc_cnt; snd_done = 0;
    out_ready = 1'b0;
    fork
      begin
        send_strip(10, 80, 10, 0);
        send_strip(20, 120, 20, 0);
        send_strip(30, 170, 30, 0);
        snd_done = 1;
      end
    join_none
    n = 0;
    while (acc_cnt - acc0 < 256 && n < 2000) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    chk("t2_accepted", acc_cnt - acc0, 256);
    chk("t2_rdy_full", in_ready, 0);
    out_ready = 1'b1;
    n = 0; prev_rdy = in_ready;
    while (out_cnt - base < 128 && n < 2000) begin
      prev_rdy = in_ready;
      @(posedge clk); #1; n++;
    end
    chk("t2_rdy_before_free", prev_rdy, 0);
    chk("t2_rdy_after_free", in_ready, 1);
    n = 0;
    while (!snd_done && n < 2000) begin @(posedge clk); n++; end
    #1;
    wait_drain(2000);
    chk("t2_count", out_cnt - base, 384);

    // Toggling sink over two strips.
    base = out_cnt; tog_en = 1;
    fork
      begin
        while (tog_en) begin @(posedge clk); #1; out_ready = ~out_ready; end
      end
    join_none
    send_strip(40, 90, 40, 0);
    send_strip(5, 190, 5, 0);
    wait_drain(3000);
    tog_en = 0;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    chk("t3_count", out_cnt - base, 256);
    @(posedge clk); #1;

    // Resync after 40 pixels of block0.
    s0 = sync_cnt; base = out_cnt;
    for (int i = 0; i < 40; i++) send2(8'(210 + i), (i == 0));
    send_strip(0, 100, 200, 0);
    wait_drain(2000);
    chk("t4_sync_pulses", sync_cnt - s0, 1);
    chk("t4_count", out_cnt - base, 128);

    // Reset while draining strip 1 with strip 2 buffered.
    out_ready = 1'b0;
    send_strip(60, 130, 60, 0);
    send_strip(70, 140, 70, 0);
    base = out_cnt;
    out_ready = 1'b1;
    n = 0;
    while (out_cnt - base < 50 && n < 2000) begin @(posedge clk); #1; n++; end
    rst = 1'b1; out_ready = 1'b0;
    q2.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_pix", out_pix, 0);
    chk("t5_line_end", out_line_end, 0);
    chk("t5_strip_end", out_strip_end, 0);
    chk("t5_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    chk("t5_no_restart", out_valid, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    base = out_cnt;
    send_strip(90, 160, 90, 1);
    wait_drain(2000);
    chk("t5_count", out_cnt - base, 128);

    // Single-block strip: output order equals input order.
    for (int i = 0; i < 64; i++) q1.push_back({8'(i), (i % 8 == 7), (i == 63)});
    for (int i = 0; i < 64; i++) send1(8'(i), (i == 0));
    wait_drain(500);
    chk("t6_count", out_cnt1, 64);

    chk("sync_total", sync_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
